// File: rtl/power_select_ctrl_if.sv
// Selection bus between the pushbutton front end and the power display logic.
// slave = controller side, master = whoever drives keys/start and consumes the code.
interface power_select_ctrl_if;
    logic [2:0] iKEY_N;
    logic       iSTART;
    logic [3:0] oSTATE;
    logic       oSTATE_VALID;
    logic       oPLAYER;
    logic [1:0] oP1_POWER;
    logic [1:0] oP2_POWER;
    logic       oDONE;

    modport master (
        output iKEY_N, iSTART,
        input  oSTATE, oSTATE_VALID, oPLAYER, oP1_POWER, oP2_POWER, oDONE
    );

    modport slave (
        input  iKEY_N, iSTART,
        output oSTATE, oSTATE_VALID, oPLAYER, oP1_POWER, oP2_POWER, oDONE
    );
endinterface

// File: rtl/power_select_ctrl.sv
// Power selection round controller: debounced keys -> P1 pick, P2 pick, timed 4-bit display code.
// Latency: oSTATE valid 1 cycle after a debounced press event, for HOLD_CYCLES cycles.
// No backpressure: presses outside a select state are dropped. POWER_SEL_NO_DUP_EN rejects P2 picks equal to P1.
module power_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    power_select_ctrl_if.slave  sel_if
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        P1_SEL,
        P1_SHOW,
        REL_WAIT,
        P2_SEL,
        P2_SHOW,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Key input path: 2-flop synchronizer, then per-key stability counter
    // ------------------------------------------------------------------
    logic [2:0]         sync1_q;
    logic [2:0]         sync2_q;
    logic [2:0]         sync_prev_q;
    logic [2:0]         deb_q;
    logic [2:0]         deb_dly_q;
    logic [2:0][CW-1:0] db_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            sync_prev_q <= 3'b111;
            deb_q       <= 3'b111;
            deb_dly_q   <= 3'b111;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= sel_if.iKEY_N;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            deb_dly_q   <= deb_q;
            for (int k = 0; k < 3; k++) begin
                if (sync2_q[k] != sync_prev_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    deb_q[k] <= sync2_q[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press event decode
    // ------------------------------------------------------------------
    logic [2:0] pressed;
    logic [2:0] press_evt;
    logic       multi_press;
    logic       evt_vld;
    logic [1:0] evt_pick;
    logic       dup_pick;

    assign pressed     = ~deb_q;
    assign press_evt   = deb_dly_q & ~deb_q;
    assign multi_press = (pressed[0] & pressed[1]) | (pressed[0] & pressed[2]) |
                         (pressed[1] & pressed[2]);
    assign evt_vld     = (|press_evt) && !multi_press;

    // With multi-press excluded, the pressed vector has exactly one bit set on a valid event.
    always_comb begin
        evt_pick = 2'b00;
        if (pressed[0])      evt_pick = 2'b01;
        else if (pressed[1]) evt_pick = 2'b10;
        else if (pressed[2]) evt_pick = 2'b11;
    end

    function automatic logic [3:0] code_of(input logic [1:0] pick);
        code_of = {2'b01, pick - 2'd1};
    endfunction

    // ------------------------------------------------------------------
    // Round FSM with registered outputs
    // ------------------------------------------------------------------
    state_t      st_q;
    logic [HW-1:0] hold_q;
    logic [3:0]  code_q;
    logic        code_vld_q;
    logic        player_q;
    logic [1:0]  p1_q;
    logic [1:0]  p2_q;
    logic        done_q;

`ifdef POWER_SEL_NO_DUP_EN
    assign dup_pick = (evt_pick == p1_q);
`else
    assign dup_pick = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            hold_q     <= '0;
            code_q     <= 4'b0000;
            code_vld_q <= 1'b0;
            player_q   <= 1'b0;
            p1_q       <= 2'b00;
            p2_q       <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (sel_if.iSTART) begin
                        player_q <= 1'b0;
                        st_q     <= P1_SEL;
                    end
                end
                P1_SEL: begin
                    if (evt_vld) begin
                        p1_q       <= evt_pick;
                        code_q     <= code_of(evt_pick);
                        code_vld_q <= 1'b1;
                        hold_q     <= HOLD_LAST;
                        st_q       <= P1_SHOW;
                    end
                end
                P1_SHOW: begin
                    if (hold_q == '0) begin
                        code_q     <= 4'b0000;
                        code_vld_q <= 1'b0;
                        player_q   <= 1'b1;
                        st_q       <= REL_WAIT;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                REL_WAIT: begin
                    // P1's key must be seen released so it cannot count as P2's pick.
                    if (&deb_q) begin
                        st_q <= P2_SEL;
                    end
                end
                P2_SEL: begin
                    if (evt_vld && !dup_pick) begin
                        p2_q       <= evt_pick;
                        code_q     <= code_of(evt_pick);
                        code_vld_q <= 1'b1;
                        hold_q     <= HOLD_LAST;
                        st_q       <= P2_SHOW;
                    end
                end
                P2_SHOW: begin
                    if (hold_q == '0) begin
                        code_q     <= 4'b0000;
                        code_vld_q <= 1'b0;
                        done_q     <= 1'b1;
                        st_q       <= DONE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                DONE: begin
                    if (sel_if.iSTART) begin
                        p1_q     <= 2'b00;
                        p2_q     <= 2'b00;
                        done_q   <= 1'b0;
                        player_q <= 1'b0;
                        st_q     <= P1_SEL;
                    end
                end
                default: begin
                    st_q       <= IDLE;
                    code_q     <= 4'b0000;
                    code_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel_if.oSTATE       = code_q;
    assign sel_if.oSTATE_VALID = code_vld_q;
    assign sel_if.oPLAYER      = player_q;
    assign sel_if.oP1_POWER    = p1_q;
    assign sel_if.oP2_POWER    = p2_q;
    assign sel_if.oDONE        = done_q;

endmodule
